trap_controller: RTL and testbench

TRAP_CONTROLLER -- requirements
Module: trap_controller

---
 rtl/trap_controller_pkg.sv | 27 ++
 rtl/trap_priority.sv | 33 +++
 rtl/trap_controller.sv | 113 +++++++++++
 tb/tb_trap_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/trap_controller_pkg.sv
// Shared core definitions for trap entry/return sequencing: FSM states and mcause encodings.
package trap_controller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } trap_state_t;

  localparam logic [4:0]  CAUSE_MEI = 5'd11;
  localparam logic [4:0]  CAUSE_MSI = 5'd3;
  localparam logic [4:0]  CAUSE_MTI = 5'd7;
  localparam int unsigned INTR_BIT  = 31;

  function automatic logic [31:0] exc_cause(input logic [4:0] code);
    return {27'b0, code};
  endfunction

  function automatic logic [31:0] intr_cause(input logic [4:0] code);
    logic [31:0] c;
    c = {27'b0, code};
    c[INTR_BIT] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/trap_priority.sv
// Combinational event selection: exception > external > software > timer > MRET.
module trap_priority
  import trap_controller_pkg::*;
(
  input  logic        exception,
  input  logic        eip,
  input  logic        sip,
  input  logic        tip,
  input  logic        mret,
  input  logic [4:0]  exc_code,
  output logic        take,
  output logic        is_mret,
  output logic [31:0] cause
);

  always_comb begin
    take    = exception | eip | sip | tip | mret;
    is_mret = 1'b0;
    cause   = '0;
    if (exception) begin
      cause = exc_cause(exc_code);
    end else if (eip) begin
      cause = intr_cause(CAUSE_MEI);
    end else if (sip) begin
      cause = intr_cause(CAUSE_MSI);
    end else if (tip) begin
      cause = intr_cause(CAUSE_MTI);
    end else if (mret) begin
      is_mret = 1'b1;
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Trap/MRET sequencer: drains the pipeline, pulses the CSR update, then redirects fetch.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_exception,
  input  logic [4:0]  wb_exc_code,
  input  logic        wb_mret,
  input  logic        eip,
  input  logic        sip,
  input  logic        tip,
  input  logic [31:0] trap_vector,
  input  logic [31:0] mret_vector,
  output logic        traped,
  output logic        mret,
  output logic [31:0] ecp,
  output logic [31:0] cause,
  output logic        flush,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  trap_state_t state, state_next;
  logic [3:0]  cnt;
  logic        kind_mret;
  logic        sel_take;
  logic        sel_mret;
  logic [31:0] sel_cause;
  logic        accept;

  trap_priority u_priority (
    .exception (wb_exception),
    .eip       (eip),
    .sip       (sip),
    .tip       (tip),
    .mret      (wb_mret),
    .exc_code  (wb_exc_code),
    .take      (sel_take),
    .is_mret   (sel_mret),
    .cause     (sel_cause)
  );

  assign accept = (state == IDLE) & wb_valid & sel_take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      ecp       <= '0;
      cause     <= '0;
      kind_mret <= 1'b0;
    end else if (accept) begin
      cnt       <= DRAIN_LOAD;
      ecp       <= wb_pc;
      cause     <= sel_cause;
      kind_mret <= sel_mret;
    end else if (state == DRAIN && cnt != '0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    state_next  = state;
    traped      = 1'b0;
    mret        = 1'b0;
    flush       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) state_next = DRAIN;
      end
      DRAIN: begin
        flush = 1'b1;
        stall = 1'b1;
        if (cnt == '0) state_next = COMMIT;
      end
      COMMIT: begin
        stall      = 1'b1;
        traped     = ~kind_mret;
        mret       = kind_mret;
        state_next = REDIRECT;
      end
      REDIRECT: begin
        // Vectors are read live here so the CSR write from COMMIT is already visible.
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = kind_mret ? mret_vector : trap_vector;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: random and directed events against a cycle-level reference model.
module tb_trap_controller;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, v1;
  logic [31:0] wb_pc;
  logic        wb_exception;
  logic [4:0]  wb_exc_code;
  logic        wb_mret;
  logic        eip, sip, tip;
  logic [31:0] trap_vector, mret_vector;

  logic        traped, mret, flush, stall, redirect, busy;
  logic [31:0] ecp, cause, redirect_pc;

  logic        u1_traped, u1_mret, u1_flush, u1_stall, u1_redirect, u1_busy;
  logic [31:0] u1_ecp, u1_cause, u1_redirect_pc;

  trap_controller #(.DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_exception(wb_exception), .wb_exc_code(wb_exc_code), .wb_mret(wb_mret),
    .eip(eip), .sip(sip), .tip(tip), .trap_vector(trap_vector), .mret_vector(mret_vector),
    .traped(traped), .mret(mret), .ecp(ecp), .cause(cause), .flush(flush), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
  );

  trap_controller #(.DRAIN_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .wb_valid(v1), .wb_pc(wb_pc),
    .wb_exception(wb_exception), .wb_exc_code(wb_exc_code), .wb_mret(wb_mret),
    .eip(eip), .sip(sip), .tip(tip), .trap_vector(trap_vector), .mret_vector(mret_vector),
    .traped(u1_traped), .mret(u1_mret), .ecp(u1_ecp), .cause(u1_cause), .flush(u1_flush),
    .stall(u1_stall), .redirect(u1_redirect), .redirect_pc(u1_redirect_pc), .busy(u1_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_mret;
    logic [31:0] ecp;
    logic [31:0] cause;
    int          issue;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   last_acc = -100;
  bit   seen_pulse = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Reference: which event wins and what mcause it produces.
  function automatic void predict(input bit exc, input bit e, input bit s, input bit t,
                                  input logic [4:0] code,
                                  output bit is_m, output logic [31:0] c);
    is_m = 1'b0;
    if (exc)    c = 32'(code);
    else if (e) c = 32'h8000_000B;
    else if (s) c = 32'h8000_0003;
    else if (t) c = 32'h8000_0007;
    else begin
      c = 32'h0;
      is_m = 1'b1;
    end
  endfunction

  // Monitor: every period, compare control levels against the model and pop on pulses.
  always @(negedge clk) begin
    bit eb, ef;
    eb = (cyc >= last_acc + 1) && (cyc <= last_acc + D + 2);
    ef = (cyc >= last_acc + 1) && (cyc <= last_acc + D);
    check("busy_flush_stall", {61'b0, busy, flush, stall}, {61'b0, eb, ef, eb});
    if (traped || mret) begin
      check("pulse_exclusive", {63'b0, traped & mret}, 64'd0);
      if (q.size() == 0) flag("unexpected_pulse");
      else begin
        check("pulse_kind", {62'b0, mret, traped}, {62'b0, q[0].is_mret, !q[0].is_mret});
        check("ecp", {32'b0, ecp}, {32'b0, q[0].ecp});
        if (!q[0].is_mret) check("cause", {32'b0, cause}, {32'b0, q[0].cause});
        check("pulse_cycle", 64'(cyc), 64'(q[0].issue + D + 1));
        seen_pulse = 1'b1;
      end
    end
    if (redirect) begin
      if (q.size() == 0) flag("unexpected_redirect");
      else begin
        exp_t e;
        e = q.pop_front();
        check("redirect_pc", {32'b0, redirect_pc},
              {32'b0, e.is_mret ? mret_vector : trap_vector});
        check("redirect_cycle", 64'(cyc), 64'(e.issue + D + 2));
        check("pulse_before_redirect", {63'b0, seen_pulse}, 64'd1);
      end
      seen_pulse = 1'b0;
    end
  end

  task automatic issue(input bit v, input bit exc, input logic [4:0] code, input logic [31:0] pc,
                       input bit e, input bit s, input bit t, input bit m);
    exp_t x;
    wb_valid = v; wb_exception = exc; wb_exc_code = code; wb_pc = pc;
    eip = e; sip = s; tip = t; wb_mret = m;
    if (v && (exc || e || s || t || m) && (cyc >= last_acc + D + 3)) begin
      predict(exc, e, s, t, code, x.is_mret, x.cause);
      x.ecp   = pc;
      x.issue = cyc;
      q.push_back(x);
      last_acc = cyc;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    wb_valid = 0; wb_exception = 0; eip = 0; sip = 0; tip = 0; wb_mret = 0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int i, tc, rc;
    reset = 1; v1 = 0; wb_valid = 0; wb_pc = 0; wb_exception = 0; wb_exc_code = 0;
    wb_mret = 0; eip = 0; sip = 0; tip = 0; trap_vector = 0; mret_vector = 0;
    #1;
    check("reset_outputs", {57'b0, busy, flush, stall, traped, mret, redirect, u1_busy}, 64'd0);
    check("reset_ecp_cause", {ecp, cause}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 0;

    trap_vector = 32'h80;
    issue(1, 1, 5'd2, 32'h100, 0, 0, 0, 0); idle(6);
    issue(1, 0, 5'd0, 32'h200, 1, 0, 1, 0); idle(6);
    mret_vector = 32'h344;
    issue(1, 0, 5'd0, 32'h300, 0, 0, 0, 1); idle(6);
    issue(1, 0, 5'd0, 32'h400, 0, 1, 0, 1); idle(6);
    issue(0, 1, 5'd5, 32'h500, 0, 0, 0, 0); idle(3);
    issue(1, 1, 5'd4, 32'h600, 0, 0, 0, 0);
    issue(1, 0, 5'd0, 32'h700, 1, 0, 0, 0); idle(6);

    issue(1, 1, 5'd3, 32'h800, 0, 0, 0, 0);
    reset = 1; q.delete(); last_acc = -100; seen_pulse = 0;
    #1;
    check("reset_mid_outputs", {58'b0, busy, flush, stall, traped, mret, redirect}, 64'd0);
    check("reset_mid_ecp_cause", {ecp, cause}, 64'd0);
    @(posedge clk); @(posedge clk); #1 reset = 0;
    idle(8);

    // DRAIN_CYCLES=1 instance: redirect three periods after the event.
    v1 = 1; wb_exception = 1; wb_exc_code = 5'd4; wb_pc = 32'h900; i = cyc;
    @(posedge clk); #1;
    v1 = 0; wb_exception = 0; tc = -1; rc = -1;
    repeat (6) begin
      @(negedge clk);
      if (u1_traped) tc = cyc;
      if (u1_redirect) rc = cyc;
    end
    check("u1_traped_cycle", 64'(tc), 64'(i + 2));
    check("u1_redirect_cycle", 64'(rc), 64'(i + 3));
    check("u1_ecp_cause", {u1_ecp, u1_cause}, {32'h900, 32'h4});
    @(posedge clk); #1;

    for (int n = 0; n < 400; n++) begin
      trap_vector = $urandom;
      mret_vector = $urandom;
      issue(($urandom % 4) != 0, ($urandom % 6) == 0, 5'($urandom), $urandom & 32'hFFFF_FFFC,
            ($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 4) == 0);
    end
    idle(8);
    check("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
